ram_access_ctrl: RTL and testbench
==================================

# ram_access_ctrl

Two-requester access controller that shares the single-port RAM between two clients. It arbitrates between them, sequences the RAM's `cs`/`we`/`oe`/`address`/`data_in` controls for one transaction at a time, and returns read data with a one-cycle acknowledge. It sits between the client logic and the `ram` instance and drives the RAM through its interface signals.

## Interface
- `ADDR_W`, 10, RAM address width
- `DATA_W`, 4, RAM data width
- `RD_LATENCY`, 1, cycles from read issue to valid `ram_data_out` (legal 1..7)
- `clk`  in  1  clock; all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `req0` / `req1`  in  1  request, held high until matching ack
- `wr0` / `wr1`  in  1  1 = write, 0 = read; sampled with grant
- `addr0` / `addr1`  in  ADDR_W  transaction address
- `wdata0` / `wdata1`  in  DATA_W  write data
- `ack0` / `ack1`  out  1  one-cycle completion pulse
- `rdata0` / `rdata1`  out  DATA_W  read data, valid while ack high, held until next ack to that port
- `busy`  out  1  high in any state except IDLE
- `ram_cs`, `ram_we`, `ram_oe`  out  1  RAM controls
- `ram_address`  out  ADDR_W  RAM address
- `ram_data_in`  out  DATA_W  RAM write data
- `ram_data_out`  in  DATA_W  RAM read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if either req is high, select winner, latch its wr/addr/wdata and id, go ISSUE; otherwise stay, all RAM controls 0.
- ISSUE (1 cycle): `ram_cs`=1, `ram_we`=latched wr, `ram_oe`=~wr, address/data_in from latch. Write → ACK. Read → WAIT, load down-counter with RD_LATENCY-1.
- WAIT: `ram_cs`=1, `ram_we`=0, `ram_oe`=1, same address. When counter is 0, capture `ram_data_out` into the winner's rdata register and go ACK; else decrement.
- ACK (1 cycle): winner's ack=1, RAM controls 0, update last-grant, go IDLE.
- Requester drops req in the cycle after seeing ack. A req still high in IDLE is a new transaction.
- Loser's req is untouched and served next; no request is starved under round-robin.
- Inputs of the loser may change freely. The winner's inputs are not re-sampled after IDLE.
- `ram_data_in` is 0 when `ram_we`=0. `ram_address` is 0 in IDLE and ACK.

## Timing
- Reset: state=IDLE, all ack/rdata/busy/ram_* outputs 0, last-grant=1 (requester 0 wins first tie), counter 0.
- Req sampled high in IDLE at edge k: write ack high in cycle k+2; read ack high in cycle k+2+RD_LATENCY.
- Back-to-back: the minimum gap between transactions is one IDLE cycle, so write throughput is 1 per 3 cycles.
- Reset asserted in any state: next cycle is IDLE with reset values. The in-flight transaction is dropped with no ack. A write already presented in ISSUE at that edge is not retried.
- `req` deasserted mid-transaction is an illegal stimulus. The transaction still completes and acks.

## Configuration
- `RAM_ACCESS_CTRL_RR_EN` defined: round-robin. On simultaneous requests, the port not granted last wins.
- Undefined: fixed priority. `req0` always wins simultaneous requests, and the last-grant register is not implemented.

## Structure
- Shared package (`ram_package`): `typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} ram_ctrl_state_t` and default `ADDR_W`/`DATA_W` constants.
- One sub-module, `ram_arb2`: combinational 2-way grant from req0/req1 and last-grant. The macro selects its policy.
- Top holds the FSM, latch, latency counter, and rdata registers.

## Test plan
- Reset: hold `reset` for 2 cycles mid-read → next cycle all outputs 0, state IDLE, no ack.
- Single write: req0, wr0=1, addr0=120, wdata0=4'b1010 → `ram_cs`=`ram_we`=1 with address 120 and data 1010 in cycle k+1; ack0 in k+2.
- Read-back: after the write above, req1 read at addr 120 → `ram_oe`=1 in ISSUE/WAIT; ack1 at k+3 (RD_LATENCY=1) with rdata1=4'b1010.
- Simultaneous: req0 and req1 high from reset, writes to 111 (4'b1111) and 112 (4'b0001) → port 0 served first, port 1 acked 3 cycles later. With RR_EN, a repeat tie grants port 1 first; without it, port 0.
- Latency sweep: RD_LATENCY=3, read → WAIT lasts 3 cycles and ack arrives at k+5.
- Back-to-back: req0 held high for 4 writes to addr 0..3 → acks spaced exactly 3 cycles apart; RAM contents match.

Source files
------------

// File: rtl/ram_package.sv
// Shared FSM state type and default bus widths for the two-requester RAM access controller.
package ram_package;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} ram_ctrl_state_t;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DATA_W = 4;
  localparam int CNT_W          = 3;
endpackage

// File: rtl/ram_arb2.sv
// Combinational 2-way grant. RAM_ACCESS_CTRL_RR_EN selects round-robin on ties;
// without it requester 0 has fixed priority and no last-grant input exists.
module ram_arb2 (
  input  logic req0,
  input  logic req1,
`ifdef RAM_ACCESS_CTRL_RR_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
`ifdef RAM_ACCESS_CTRL_RR_EN
    grant_id = (req0 && req1) ? ~last_grant : req1;
`else
    grant_id = ~req0 & req1;
`endif
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Shares one single-port RAM between two requesters, one transaction at a time.
// Define RAM_ACCESS_CTRL_RR_EN for round-robin arbitration; default is fixed priority.
module ram_access_ctrl
  import ram_package::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  ram_ctrl_state_t   state_q, state_d;
  logic              id_q, id_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              busy_q, busy_d;
  logic              ram_cs_q, ram_cs_d, ram_we_q, ram_we_d, ram_oe_q, ram_oe_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;

  logic              grant_valid, grant_id;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef RAM_ACCESS_CTRL_RR_EN
  logic last_grant_q, last_grant_d;

  ram_arb2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );
`else
  ram_arb2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );
`endif

  assign sel_wr    = grant_id ? wr1    : wr0;
  assign sel_addr  = grant_id ? addr1  : addr0;
  assign sel_wdata = grant_id ? wdata1 : wdata0;

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    ram_cs_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_oe_d      = 1'b0;
    ram_address_d = '0;
    ram_data_in_d = '0;
`ifdef RAM_ACCESS_CTRL_RR_EN
    last_grant_d  = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d       = ISSUE;
          id_d          = grant_id;
          wr_d          = sel_wr;
          addr_d        = sel_addr;
          wdata_d       = sel_wdata;
          ram_cs_d      = 1'b1;
          ram_we_d      = sel_wr;
          ram_oe_d      = ~sel_wr;
          ram_address_d = sel_addr;
          ram_data_in_d = sel_wr ? sel_wdata : '0;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          state_d = ACK;
          ack0_d  = ~id_q;
          ack1_d  = id_q;
        end else begin
          state_d       = WAIT;
          cnt_d         = CNT_W'(RD_LATENCY - 1);
          ram_cs_d      = 1'b1;
          ram_oe_d      = 1'b1;
          ram_address_d = addr_q;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACK;
          ack0_d  = ~id_q;
          ack1_d  = id_q;
          if (id_q) rdata1_d = ram_data_out;
          else      rdata0_d = ram_data_out;
        end else begin
          cnt_d         = cnt_q - 1'b1;
          ram_cs_d      = 1'b1;
          ram_oe_d      = 1'b1;
          ram_address_d = addr_q;
        end
      end
      ACK: begin
        state_d = IDLE;
`ifdef RAM_ACCESS_CTRL_RR_EN
        last_grant_d = id_q;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      id_q          <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      busy_q        <= 1'b0;
      ram_cs_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_oe_q      <= 1'b0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
`ifdef RAM_ACCESS_CTRL_RR_EN
      last_grant_q  <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      busy_q        <= busy_d;
      ram_cs_q      <= ram_cs_d;
      ram_we_q      <= ram_we_d;
      ram_oe_q      <= ram_oe_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
`ifdef RAM_ACCESS_CTRL_RR_EN
      last_grant_q  <= last_grant_d;
`endif
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign busy        = busy_q;
  assign ram_cs      = ram_cs_q;
  assign ram_we      = ram_we_q;
  assign ram_oe      = ram_oe_q;
  assign ram_address = ram_address_q;
  assign ram_data_in = ram_data_in_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench: one controller with a 1-cycle RAM model, a second with a 3-cycle read pipeline.
module tb_ram_access_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT with RD_LATENCY = 1 ----------------
  logic       req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [9:0] addr0 = 0, addr1 = 0;
  logic [3:0] wdata0 = 0, wdata1 = 0;
  logic       ack0, ack1, busy, ram_cs, ram_we, ram_oe;
  logic [3:0] rdata0, rdata1, ram_data_in, ram_data_out;
  logic [9:0] ram_address;

  ram_access_ctrl #(.ADDR_W(10), .DATA_W(4), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  logic [3:0] mem [0:1023];
  logic [3:0] rd_q;
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_address] <= ram_data_in;
    rd_q <= (ram_cs && ram_oe) ? mem[ram_address] : 4'h0;
  end
  assign ram_data_out = rd_q;

  // ---------------- DUT with RD_LATENCY = 3 ----------------
  logic       req0_3 = 0, req1_3 = 0, wr0_3 = 0, wr1_3 = 0;
  logic [9:0] addr0_3 = 0, addr1_3 = 0;
  logic [3:0] wdata0_3 = 0, wdata1_3 = 0;
  logic       ack0_3, ack1_3, busy_3, ram_cs_3, ram_we_3, ram_oe_3;
  logic [3:0] rdata0_3, rdata1_3, ram_data_in_3, ram_data_out_3;
  logic [9:0] ram_address_3;

  ram_access_ctrl #(.ADDR_W(10), .DATA_W(4), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0(req0_3), .req1(req1_3), .wr0(wr0_3), .wr1(wr1_3),
    .addr0(addr0_3), .addr1(addr1_3), .wdata0(wdata0_3), .wdata1(wdata1_3),
    .ack0(ack0_3), .ack1(ack1_3), .rdata0(rdata0_3), .rdata1(rdata1_3), .busy(busy_3),
    .ram_cs(ram_cs_3), .ram_we(ram_we_3), .ram_oe(ram_oe_3),
    .ram_address(ram_address_3), .ram_data_in(ram_data_in_3), .ram_data_out(ram_data_out_3)
  );

  function automatic logic [3:0] rom3(input logic [9:0] a);
    return a[3:0] ^ a[7:4];
  endfunction

  logic [3:0] p3 [0:2];
  always @(posedge clk) begin
    p3[0] <= (ram_cs_3 && ram_oe_3) ? rom3(ram_address_3) : 4'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign ram_data_out_3 = p3[2];

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Counts edges until an ack is seen at the following negedge; start is edges already consumed.
  task automatic wait_ack(input int start, output int port, output int delay);
    bit seen;
    port  = -1;
    delay = start;
    seen  = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk);
      @(negedge clk);
      delay++;
      if (ack0 || ack1) begin
        seen = 1;
        port = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no ack after %0d cycles, expected one", delay);
    end
  endtask

  task automatic drive(input int port, input logic r, input logic w,
                       input logic [9:0] a, input logic [3:0] d);
    if (port == 0) begin req0 = r; wr0 = w; addr0 = a; wdata0 = d; end
    else           begin req1 = r; wr1 = w; addr1 = a; wdata1 = d; end
  endtask

  typedef struct {
    int         port;
    logic       wr;
    logic [9:0] addr;
    logic [3:0] wdata;
    logic [3:0] exp_rd0;
    logic [3:0] exp_rd1;
    int         exp_delay;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  int p, d, oe_cycles;
  bit got3;
  logic [31:0] all_out;

  initial begin
    // port, wr, addr, wdata, rdata0 after, rdata1 after, req-to-ack cycles
    vecs[0] = '{0, 1'b1, 10'd120,  4'b1010, 4'h0, 4'h0, 2};
    vecs[1] = '{1, 1'b0, 10'd120,  4'h0,    4'h0, 4'hA, 3};
    vecs[2] = '{1, 1'b1, 10'd5,    4'h3,    4'h0, 4'hA, 2};
    vecs[3] = '{0, 1'b0, 10'd5,    4'h0,    4'h3, 4'hA, 3};
    vecs[4] = '{0, 1'b1, 10'd1023, 4'h6,    4'h3, 4'hA, 2};
    vecs[5] = '{1, 1'b0, 10'd1023, 4'h0,    4'h3, 4'h6, 3};
    vecs[6] = '{0, 1'b1, 10'd0,    4'hF,    4'h3, 4'h6, 2};
    vecs[7] = '{1, 1'b0, 10'd0,    4'h0,    4'h3, 4'hF, 3};
    vecs[8] = '{0, 1'b0, 10'd112,  4'h0,    4'h1, 4'hF, 3};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    all_out = {10'd0, ack0, ack1, busy, ram_cs, ram_we, ram_oe, ram_address, ram_data_in, rdata0, rdata1};
    check("reset_outputs", all_out, 32'h0);
    all_out = {10'd0, ack0_3, ack1_3, busy_3, ram_cs_3, ram_we_3, ram_oe_3, ram_address_3,
               ram_data_in_3, rdata0_3, rdata1_3};
    check("reset_outputs_lat3", all_out, 32'h0);

    // Simultaneous writes from reset, then a repeat tie with req0 kept high
    drive(0, 1, 1, 10'd111, 4'b1111);
    drive(1, 1, 1, 10'd112, 4'b0001);
    @(posedge clk); #1 reset = 0;
    wait_ack(0, p, d);
    check("tie1_port", 32'(p), 0);
    check("tie1_delay", 32'(d), 2);
    $display("tie1: port %0d acked after %0d cycles", p, d);
    addr0 = 10'd113; wdata0 = 4'b0101;
    wait_ack(0, p, d);
`ifdef RAM_ACCESS_CTRL_RR_EN
    check("tie2_port", 32'(p), 1);
`else
    check("tie2_port", 32'(p), 0);
`endif
    check("tie2_delay", 32'(d), 3);
    $display("tie2: port %0d acked after %0d cycles", p, d);
    if (p == 1) req1 = 0; else if (p == 0) req0 = 0; else begin req0 = 0; req1 = 0; end
    wait_ack(0, p, d);
`ifdef RAM_ACCESS_CTRL_RR_EN
    check("tie3_port", 32'(p), 0);
`else
    check("tie3_port", 32'(p), 1);
`endif
    check("tie3_delay", 32'(d), 3);
    $display("tie3: port %0d acked after %0d cycles", p, d);
    req0 = 0; req1 = 0;
    check("tie_mem111", 32'(mem[111]), 32'hF);
    check("tie_mem112", 32'(mem[112]), 32'h1);
    check("tie_mem113", 32'(mem[113]), 32'h5);

    // Back-to-back writes with req0 held high
    @(posedge clk); #1;
    drive(0, 1, 1, 10'd0, 4'h8);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        addr0  = 10'(i);
        wdata0 = 4'(8 + i);
      end
      wait_ack(0, p, d);
      check("b2b_port", 32'(p), 0);
      check("b2b_spacing", 32'(d), (i == 0) ? 32'd2 : 32'd3);
      $display("b2b write %0d: port %0d acked after %0d cycles", i, p, d);
    end
    req0 = 0;
    for (int i = 0; i < 4; i++) check("b2b_mem", 32'(mem[i]), 32'(8 + i));

    // Table of single-port transactions
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].port, 1, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      @(posedge clk);
      @(negedge clk);
      check("issue_cs",   32'(ram_cs), 1);
      check("issue_we",   32'(ram_we), 32'(vecs[i].wr));
      check("issue_oe",   32'(ram_oe), 32'(!vecs[i].wr));
      check("issue_addr", 32'(ram_address), 32'(vecs[i].addr));
      check("issue_din",  32'(ram_data_in), vecs[i].wr ? 32'(vecs[i].wdata) : 32'h0);
      check("issue_busy", 32'(busy), 1);
      wait_ack(1, p, d);
      check("vec_port",   32'(p), 32'(vecs[i].port));
      check("vec_delay",  32'(d), 32'(vecs[i].exp_delay));
      check("vec_rdata0", 32'(rdata0), 32'(vecs[i].exp_rd0));
      check("vec_rdata1", 32'(rdata1), 32'(vecs[i].exp_rd1));
      check("ack_ctrl",   {22'd0, ram_cs, ram_we, ram_oe, 1'b0, ram_address[5:0]}, 32'h0);
      $display("vec %0d: port %0d %s addr %0d -> ack port %0d after %0d cycles, rdata0=%h rdata1=%h",
               i, vecs[i].port, vecs[i].wr ? "write" : "read", vecs[i].addr, p, d, rdata0, rdata1);
      drive(vecs[i].port, 0, 0, 10'd0, 4'h0);
      @(posedge clk); @(negedge clk);
      check("idle_addr", 32'(ram_address), 0);
      check("idle_busy", 32'(busy), 0);
    end

    // Reset held for two cycles in the middle of a read
    @(posedge clk); #1;
    drive(1, 1, 0, 10'd120, 4'h0);
    @(posedge clk);
    @(negedge clk);
    check("rst_issue_oe", 32'(ram_oe), 1);
    reset = 1;
    req1  = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      all_out = {10'd0, ack0, ack1, busy, ram_cs, ram_we, ram_oe, ram_address, ram_data_in, rdata0, rdata1};
      check("rst_mid_read", all_out, 32'h0);
    end
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_no_ack", {30'd0, ack0, ack1}, 32'h0);
      check("rst_idle", 32'(busy), 0);
    end
    $display("reset mid-read: outputs cleared, transaction dropped");

    // Latency sweep on the RD_LATENCY=3 instance
    @(posedge clk); #1;
    req0_3 = 1; wr0_3 = 0; addr0_3 = 10'h029;
    @(posedge clk);
    d = 0;
    oe_cycles = 0;
    got3 = 0;
    for (int n = 0; n < 20 && !got3; n++) begin
      @(negedge clk);
      if (n == 0) begin
        check("lat3_issue_addr", 32'(ram_address_3), 32'h029);
        check("lat3_issue_we",   32'(ram_we_3), 0);
        check("lat3_issue_din",  32'(ram_data_in_3), 0);
      end
      d++;
      if (ram_oe_3 && ram_cs_3) oe_cycles++;
      if (ack0_3 || ack1_3) got3 = 1;
      else @(posedge clk);
    end
    check("lat3_acked",     32'(got3), 1);
    check("lat3_delay",     32'(d), 5);
    check("lat3_oe_cycles", 32'(oe_cycles), 4);
    check("lat3_rdata0",    32'(rdata0_3), 32'hB);
    check("lat3_port",      {30'd0, ack1_3, ack0_3}, 32'h1);
    $display("latency3 read: ack after %0d cycles, %0d read-enable cycles, rdata0=%h", d, oe_cycles, rdata0_3);
    req0_3 = 0;
    @(posedge clk); @(negedge clk);
    check("lat3_rdata1", 32'(rdata1_3), 0);
    check("lat3_busy_after", 32'(busy_3), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
